// File: rtl/sram_ctrl_if.sv
// sram_ctrl_if: CPU-side request/response bundle for sram_ctrl.
//
// Handshake: req is a request level sampled only while the controller is
// idle (busy=0); we/addr/wdata are captured on the same edge. A request
// raised while busy=1 is dropped, not queued. done is a single-cycle pulse
// marking the end of the transaction, and rdata is valid from that cycle
// onwards.
//
// Signals:
//   req    - start a transaction
//   we     - 1 = write, 0 = read
//   addr   - 8-bit SRAM address
//   wdata  - 8-bit write data
//   rdata  - registered read data, holds the last read value
//   busy   - high while a transaction is in progress
//   done   - one-cycle completion pulse
interface sram_ctrl_if;
  logic       req;
  logic       we;
  logic [7:0] addr;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       busy;
  logic       done;

  modport master (
    output req, we, addr, wdata,
    input  rdata, busy, done
  );

  modport slave (
    input  req, we, addr, wdata,
    output rdata, busy, done
  );
endinterface

// File: rtl/sram_ctrl.sv
// sram_ctrl: runs one asynchronous-SRAM cycle per request, in the order
// SETUP -> ACCESS (WAIT_CYCLES cycles) -> RECOVER. Every SRAM pin is driven
// from a flop, so the strobes cannot glitch.
//
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   bus        - CPU-side request/response interface (slave modport)
//   sram_addr  - registered SRAM address
//   sram_dq    - SRAM data bus; driven only during a write transaction
//   sram_ce_n  - chip enable, active low
//   sram_oe_n  - output enable, active low
//   sram_we_n  - write enable, active low
//   state_dbg  - current FSM state (0 IDLE, 1 SETUP, 2 ACCESS, 3 RECOVER)
module sram_ctrl #(
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  sram_ctrl_if.slave  bus,
  output logic [7:0]  sram_addr,
  inout  wire  [7:0]  sram_dq,
  output logic        sram_ce_n,
  output logic        sram_oe_n,
  output logic        sram_we_n,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETUP   = 2'd1,
    ACCESS  = 2'd2,
    RECOVER = 2'd3
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

  state_t     state;
  logic [3:0] cnt;
  logic       we_q;
  logic [7:0] wdata_q;
  logic       dq_oe;
  logic       done_q;
  logic [7:0] rdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      we_q      <= 1'b0;
      wdata_q   <= 8'h00;
      dq_oe     <= 1'b0;
      done_q    <= 1'b0;
      rdata_q   <= 8'h00;
      sram_addr <= 8'h00;
      sram_ce_n <= 1'b1;
      sram_oe_n <= 1'b1;
      sram_we_n <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.req) begin
            state     <= SETUP;
            we_q      <= bus.we;
            wdata_q   <= bus.wdata;
            sram_addr <= bus.addr;
            cnt       <= CNT_LOAD;
            sram_ce_n <= 1'b0;
            // A read enables the SRAM output straight away. A write starts
            // driving data here, so dq is set up one cycle before we_n falls.
            sram_oe_n <= bus.we;
            sram_we_n <= 1'b1;
            dq_oe     <= bus.we;
          end
        end
        SETUP: begin
          state     <= ACCESS;
          sram_we_n <= ~we_q;
        end
        ACCESS: begin
          if (cnt == 4'd0) begin
            state     <= RECOVER;
            sram_oe_n <= 1'b1;
            sram_we_n <= 1'b1;
            done_q    <= 1'b1;
            if (!we_q) begin
              rdata_q <= sram_dq;
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RECOVER: begin
          // dq has stayed driven through RECOVER, so the write data is held
          // for one cycle after we_n rises.
          state     <= IDLE;
          done_q    <= 1'b0;
          sram_ce_n <= 1'b1;
          dq_oe     <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign sram_dq   = dq_oe ? wdata_q : 8'hzz;
  assign bus.busy  = (state != IDLE);
  assign bus.done  = done_q;
  assign bus.rdata = rdata_q;
  assign state_dbg = state;

endmodule

// File: doc/sram_ctrl.md
# sram_ctrl

Memory-side stage of the tinycpu: consumes the 8-bit address selected by the data-path address mux (rP for fetch, rM for load/store) plus a read/write request from cpu_control. It runs one asynchronous-SRAM cycle per request with configurable wait states. Read data is returned on a registered bus that feeds the rA load-from-memory mux input; for instruction fetch it also feeds the instruction register. All SRAM strobes are registered and glitch-free.

## Interface
- WAIT_CYCLES, 1: number of cycles the strobe (oe_n/we_n) is held in ACCESS; legal range 1..15.
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- req  input  1  start a transaction; sampled only in IDLE
- we  input  1  1 = write, 0 = read; sampled with req
- addr  input  8  transaction address from the data-path address mux
- wdata  input  8  write data (rA); sampled with req
- rdata  output  8  registered read data; holds the last read value
- busy  output  1  high whenever state is not IDLE
- done  output  1  one-cycle pulse in RECOVER
- sram_addr  output  8  registered SRAM address
- sram_dq  inout  8  SRAM data bus; driven only during a write transaction, else high-Z
- sram_ce_n, sram_oe_n, sram_we_n  output  1 each  active-low SRAM strobes, registered

## Operation
- States: IDLE, SETUP, ACCESS, RECOVER.
- IDLE: if req=1, latch addr/we/wdata, load the wait counter with WAIT_CYCLES-1, and go to SETUP. Otherwise stay in IDLE.
- SETUP (1 cycle):
  - sram_ce_n=0 and sram_addr is valid.
  - Read: sram_oe_n=0.
  - Write: sram_dq is driven with the latched wdata; sram_oe_n=1, sram_we_n=1.
  - Next state is ACCESS.
- ACCESS (WAIT_CYCLES cycles):
  - Read: sram_oe_n=0. Write: sram_we_n=0 and data is still driven.
  - The counter decrements each cycle; when it reaches 0, go to RECOVER.
  - Read: sram_dq is captured into rdata at the edge that leaves ACCESS.
- RECOVER (1 cycle):
  - sram_oe_n=1, sram_we_n=1, sram_ce_n=0, done=1.
  - Write data remains driven, which gives hold time after the we_n rising edge.
  - Next state is IDLE.
- Strobes are never active outside a transaction. sram_we_n and sram_oe_n are never both low.
- req while busy is ignored, with no queueing; cpu_control must wait for done.
- rdata is unchanged by write transactions and by reset-free idle periods.
- Counter is 4 bits. WAIT_CYCLES outside 1..15 is illegal; behaviour for those values is unspecified.

## Timing
- Reset values:
  - state=IDLE, busy=0, done=0, rdata=8'h00, sram_addr=8'h00.
  - sram_ce_n=1, sram_oe_n=1, sram_we_n=1, sram_dq high-Z.
- Reset mid-transaction aborts the transaction at the next edge. All strobes deassert and dq releases on that edge. No done pulse is issued and rdata is not updated.
- Cycle numbering: req sampled at edge 0.
  - SETUP occupies cycles 1.
  - ACCESS occupies cycles 2..1+W.
  - RECOVER occupies cycle 2+W, with done high.
  - IDLE at cycle 3+W.
- Read data is valid on rdata from cycle 2+W, coincident with done.
- Total occupancy is W+2 busy cycles; the earliest next accepted req is at edge 3+W, giving W+3 cycles per back-to-back transaction.
- sram_we_n low for exactly W cycles.
- sram_addr and sram_dq (write) are stable from 1 cycle before we_n falls to 1 cycle after it rises.

## Test plan
- Reset: assert rst for 2 cycles mid-idle -> all strobes 1, dq Z, rdata=00, busy=0, done=0.
- Read, W=1: SRAM model holds 8'hA5 at 8'h3C; req=1, we=0, addr=3C -> oe_n low cycles 1–2, done and rdata=A5 at cycle 3, busy low at cycle 4.
- Write, W=3: req=1, we=1, addr=10, wdata=5A -> we_n low exactly cycles 2–4, dq=5A over cycles 1–5, done at cycle 5. A subsequent read of 10 returns 5A.
- Ignored request: pulse req with addr=77 during ACCESS of a read to 3C -> exactly one transaction, to 3C. No second done.
- Abort: assert rst during ACCESS of a write -> we_n=1 and dq Z the next cycle, no done, model memory unchanged or partially written per model. Controller returns to IDLE.
- Back-to-back: hold req=1 continuously, alternating write 0xC3 to 0x20 then read of 0x20 -> a new transaction every W+3 cycles, read returns C3. rdata is unchanged across the write.
